// File: rtl/rambam_pkg.sv
// rambam_pkg: shared constants and types for the RAMBAM redundant-domain decoder
package rambam_pkg;
  localparam int D = 4;
  localparam logic [0:8] AES_P = 9'h11B;
  typedef logic [0:7+D] rambam_elem_t;
  typedef logic [0:7] byte_t;
  typedef enum logic {IDLE, RUN} dec_state_t;
endpackage

// File: rtl/rambam_decoder_serial_modular_reduce_step.sv
// modular_reduce_step: one conditional XOR of P aligned at position k of a redundant element.
module modular_reduce_step
    import rambam_pkg::*;
#(
    parameter int         d = D,
    parameter logic [0:8] P = AES_P
) (
    input  logic [0:7+d]            work,
    input  logic [$clog2(d+1)-1:0]  k,
    output logic [0:7+d]            work_o
);
    logic [0:7+d] mask;
    always_comb begin
        mask   = ((8+d)'(P) << (d-1)) >> k;
        work_o = work[k] ? work ^ mask : work;
    end
endmodule

// File: rtl/rambam_decoder_serial.sv
// rambam_decoder_serial: serial reducer of an (8+d)-bit redundant element to a GF(2^8) byte.
// Define RAMBAM_DECODER_CLEAR_EN to zero the work register after each completion.
module rambam_decoder_serial
    import rambam_pkg::*;
#(
    parameter int         d = D,
    parameter logic [0:8] P = AES_P
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          drdy_i,
    input  logic [0:7+d]  in,
    output logic          drdy_o,
    output logic          busy,
    output byte_t         out
);
    localparam int CW = $clog2(d+1);
    dec_state_t      state_q, state_d;
    logic [0:7+d]    work_q, work_d, step;
    logic [CW-1:0]   cnt_q, cnt_d;
    byte_t           out_q, out_d;
    logic            drdy_q, drdy_d;

    modular_reduce_step #(.d(d), .P(P)) u_step (.work(work_q), .k(cnt_q), .work_o(step));

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        drdy_d  = 1'b0;
        if (drdy_i) begin
            state_d = RUN;
            work_d  = in;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            work_d = step;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(d-1)) begin
                state_d = IDLE;
                drdy_d  = 1'b1;
                out_d   = step[d+:8];
                `ifdef RAMBAM_DECODER_CLEAR_EN
                work_d  = '0;
                `endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            drdy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            drdy_q  <= drdy_d;
        end
    end

    assign drdy_o = drdy_q;
    assign busy   = (state_q == RUN);
    assign out    = out_q;
endmodule

// File: tb/tb_rambam_decoder_serial.sv
// tb_rambam_decoder_serial: randomized and directed checks against a polynomial-division model.
module tb_rambam_decoder_serial;
    import rambam_pkg::*;
    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            drdy_i = 1'b0;
    logic [7+D:0]    in = '0;
    logic            drdy_o, busy;
    logic [7:0]      out;
    int              n_vec = 0, n_err = 0;
    logic [7:0]      prev = 8'h00;

    rambam_decoder_serial dut (.clk(clk), .rst(rst), .drdy_i(drdy_i), .in(in),
                               .drdy_o(drdy_o), .busy(busy), .out(out));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_red(input logic [7+D:0] v);
        for (int i = 7 + D; i >= 8; i--)
            if (v[i]) v = v ^ ((8+D)'(AES_P) << (i - 8));
        return v[7:0];
    endfunction

    task automatic start(input logic [7+D:0] v);
        drdy_i = 1'b1;
        in     = v;
        @(posedge clk); #1;
        drdy_i = 1'b0;
    endtask

    task automatic wait_done(input logic [7:0] exp);
        int n = 0;
        check("busy_run", busy, 1);
        while (!drdy_o && n < 3 * D) begin
            @(posedge clk); #1;
            n++;
            if (!drdy_o) check("hold", out, prev);
        end
        check("latency", n, D);
        check("out", out, exp);
        `ifdef RAMBAM_DECODER_CLEAR_EN
        check("work_clr", 32'(dut.work_q), 0);
        `else
        check("work_keep", 32'(dut.work_q), 32'(exp));
        `endif
        prev = exp;
        @(posedge clk); #1;
        check("pulse", drdy_o, 0);
        check("idle", busy, 0);
    endtask

    initial begin
        logic [7+D:0] v;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_drdy", drdy_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        start(12'h0A5); wait_done(8'hA5);
        start(12'h100); wait_done(8'h1B);
        start(12'h800); wait_done(8'hD8);
        start(12'h8D8); wait_done(8'h00);
        start(12'h000); wait_done(8'h00);
        start(12'h100); wait_done(8'h1B);
        start(12'h800); wait_done(8'hD8);
        // abort: second start two cycles after the first
        start(12'h800);
        @(posedge clk); #1;
        check("abort_nodrdy", drdy_o, 0);
        start(12'h100); wait_done(8'h1B);
        // restart exactly on the completion edge suppresses that result
        start(12'h0FF);
        repeat (D - 1) @(posedge clk);
        #1;
        start(12'h800);
        check("cedge_nodrdy", drdy_o, 0);
        check("cedge_out", out, prev);
        wait_done(8'hD8);
        // reset mid-run
        start(12'h5A5);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mrst_out", out, 0);
        check("mrst_busy", busy, 0);
        check("mrst_drdy", drdy_o, 0);
        prev = 8'h00;
        repeat (D + 2) begin
            @(posedge clk); #1;
            check("mrst_quiet", drdy_o, 0);
        end
        start(12'h100); wait_done(8'h1B);
        for (int i = 0; i < 40; i++) begin
            v = (8+D)'($urandom);
            start(v);
            wait_done(ref_red(v));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
